// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory handshake with LDI/STI indirection and LDB/STB byte steering.
// Optional watchdog on dmem_resp is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_valid,
    input  logic [3:0]  opcode,
    input  logic        mem2_read,
    input  logic        mem2_write,
    input  logic [1:0]  mem_byte_en,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_en,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic [15:0] mem_rdata,
    output logic        mem_err
);

    // state  | meaning
    // IDLE   | waiting for a live memory request from EX/MEM
    // ACCESS | first (or only) access outstanding
    // INDIR  | second access of LDI/STI, address = fetched pointer
    // DONE   | access finished, stall released for one cycle
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_INDIR  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic [1:0] state;
    logic       is_indir;
    logic       is_ldi;
    logic       is_byte;
    logic       req;
    logic       indir_op;
    logic       byte_op;
    logic       waiting;
    logic       timeout_hit;

    assign req       = exmem_valid & (mem2_read | mem2_write);
    assign mem_stall = req & (state != S_DONE);
    assign indir_op  = (opcode == OP_LDI) | (opcode == OP_STI);
    assign byte_op   = (mem_byte_en == 2'b01) & ~indir_op;
    assign waiting   = (state == S_ACCESS) | (state == S_INDIR);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog;
    logic       err_q;

    assign timeout_hit = waiting & ~dmem_resp & (wdog == 8'd0);
    assign mem_err     = err_q;

    // Down-counter reloaded on every entry to ACCESS/INDIR; terminal count at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            if ((state == S_IDLE && req) || (state == S_ACCESS && dmem_resp && is_indir))
                wdog <= WDOG_LOAD;
            else if (waiting && !dmem_resp && wdog != 8'd0)
                wdog <= wdog - 8'd1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            dmem_address <= 16'h0000;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_byte_en <= 2'b00;
            dmem_wdata   <= 16'h0000;
            mem_rdata    <= 16'h0000;
            is_indir     <= 1'b0;
            is_ldi       <= 1'b0;
            is_byte      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state        <= S_ACCESS;
                        dmem_address <= addr;
                        is_indir     <= indir_op;
                        is_ldi       <= (opcode == OP_LDI);
                        is_byte      <= byte_op;
                        // Indirect ops always start with a pointer fetch; otherwise read wins a tie.
                        if (indir_op) begin
                            dmem_read  <= 1'b1;
                            dmem_write <= 1'b0;
                        end else begin
                            dmem_read  <= mem2_read;
                            dmem_write <= mem2_write & ~mem2_read;
                        end
                        if (byte_op) begin
                            dmem_byte_en <= addr[0] ? 2'b10 : 2'b01;
                            dmem_wdata   <= {store_data[7:0], store_data[7:0]};
                        end else begin
                            dmem_byte_en <= 2'b11;
                            dmem_wdata   <= store_data;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_resp) begin
                        if (is_indir) begin
                            state        <= S_INDIR;
                            dmem_address <= dmem_rdata;
                            dmem_read    <= is_ldi;
                            dmem_write   <= ~is_ldi;
                            dmem_byte_en <= 2'b11;
                        end else begin
                            if (dmem_read) begin
                                if (is_byte)
                                    mem_rdata <= {8'h00, dmem_address[0] ? dmem_rdata[15:8]
                                                                         : dmem_rdata[7:0]};
                                else
                                    mem_rdata <= dmem_rdata;
                            end
                            dmem_read  <= 1'b0;
                            dmem_write <= 1'b0;
                            state      <= S_DONE;
                        end
                    end else if (timeout_hit) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        mem_rdata  <= 16'h0000;
                        state      <= S_DONE;
                    end
                end
                S_INDIR: begin
                    if (dmem_resp) begin
                        if (is_ldi)
                            mem_rdata <= dmem_rdata;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        state      <= S_DONE;
                    end else if (timeout_hit) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        mem_rdata  <= 16'h0000;
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized loads/stores
// against an operation-level reference model with a reactive memory responder.
module tb_mem_stage_ctrl;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic        clk = 1'b0;
    logic        reset;
    logic        exmem_valid;
    logic [3:0]  opcode;
    logic        mem2_read;
    logic        mem2_write;
    logic [1:0]  mem_byte_en;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_en;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    logic [15:0] mem_rdata;
    logic        mem_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] model_rdata;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .exmem_valid(exmem_valid), .opcode(opcode),
        .mem2_read(mem2_read), .mem2_write(mem2_write), .mem_byte_en(mem_byte_en),
        .addr(addr), .store_data(store_data), .dmem_address(dmem_address),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_en(dmem_byte_en),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one instruction, plays a memory that answers d cycles after the strobe
    // first appears, and compares the observed transaction against the model.
    task automatic run_op(input string tag, input logic [3:0] op, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] a, input logic [15:0] sd,
                          input int d0, input int d1, input logic [15:0] r0, input logic [15:0] r1);
        logic [15:0] acc_addr [2];
        logic        acc_wr   [2];
        logic        acc_rd   [2];
        logic [1:0]  acc_be   [2];
        logic [15:0] acc_wd   [2];
        int  stalls, nacc, acc_cyc, d;
        bit  done;
        bit  indir, byte_op, exp_write, is_load;
        int  exp_n, exp_stall;
        logic [1:0]  exp_be;
        logic [15:0] exp_wd;

        indir     = (op == OP_LDI) || (op == OP_STI);
        byte_op   = (be == 2'b01) && !indir;
        exp_n     = indir ? 2 : 1;
        exp_stall = 1 + (d0 + 1) + (indir ? d1 + 1 : 0);
        exp_write = (op == OP_STI) || (!indir && wr && !rd);
        is_load   = (op == OP_LDI) || (!indir && rd);
        exp_be    = byte_op ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        exp_wd    = byte_op ? {sd[7:0], sd[7:0]} : sd;
        if (op == OP_LDI)      model_rdata = r1;
        else if (is_load)      model_rdata = byte_op ? {8'h00, a[0] ? r0[15:8] : r0[7:0]} : r0;

        stalls = 0; nacc = 0; acc_cyc = 0; done = 0;
        @(negedge clk);
        exmem_valid = 1'b1; opcode = op; mem2_read = rd; mem2_write = wr;
        mem_byte_en = be; addr = a; store_data = sd;
        for (int c = 0; c < 80 && !done; c++) begin
            #1;
            if (!mem_stall) done = 1;
            else begin
                stalls++;
                dmem_resp = 1'b0;
                if (dmem_read || dmem_write) begin
                    acc_cyc++;
                    if (acc_cyc == 1 && nacc < 2) begin
                        acc_addr[nacc] = dmem_address; acc_wr[nacc] = dmem_write;
                        acc_rd[nacc] = dmem_read; acc_be[nacc] = dmem_byte_en;
                        acc_wd[nacc] = dmem_wdata;
                    end
                    d = (nacc == 0) ? d0 : d1;
                    if (acc_cyc == d + 1) begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = (nacc == 0) ? r0 : r1;
                        nacc++;
                        acc_cyc = 0;
                    end
                end
                @(negedge clk);
            end
        end
        dmem_resp = 1'b0;
        dmem_rdata = 16'($urandom);
        check({tag, ".completed"}, 16'(done), 16'd1);
        check({tag, ".stall_cycles"}, 16'(stalls), 16'(exp_stall));
        check({tag, ".accesses"}, 16'(nacc), 16'(exp_n));
        check({tag, ".addr0"}, acc_addr[0], a);
        if (indir) begin
            check({tag, ".ptr_fetch_is_read"}, {acc_rd[0], acc_wr[0]}, 16'b10);
            check({tag, ".addr1"}, acc_addr[1], r0);
        end
        check({tag, ".final_write"}, 16'(acc_wr[exp_n - 1]), 16'(exp_write));
        check({tag, ".final_read"}, 16'(acc_rd[exp_n - 1]), 16'(!exp_write));
        if (exp_write) begin
            check({tag, ".byte_en"}, 16'(acc_be[exp_n - 1]), 16'(exp_be));
            check({tag, ".wdata"}, acc_wd[exp_n - 1], exp_wd);
        end
        check({tag, ".mem_rdata"}, mem_rdata, model_rdata);
        check({tag, ".mem_err"}, 16'(mem_err), 16'd0);
        exmem_valid = 1'b0;
        @(negedge clk); #1;
        check({tag, ".idle_quiet"}, {mem_stall, dmem_read, dmem_write}, 16'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic        rd, wr;
        logic [1:0]  be;
        logic [15:0] a, p;
        int strobe_cycles;

        reset = 1'b1; exmem_valid = 1'b0; opcode = 4'h0; mem2_read = 1'b0; mem2_write = 1'b0;
        mem_byte_en = 2'b00; addr = 16'h0; store_data = 16'h0; dmem_rdata = 16'h0; dmem_resp = 1'b0;
        model_rdata = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check("reset.strobes", {dmem_read, dmem_write}, 16'd0);
        check("reset.address", dmem_address, 16'h0000);
        check("reset.byte_en", 16'(dmem_byte_en), 16'd0);
        check("reset.wdata", dmem_wdata, 16'h0000);
        check("reset.mem_rdata", mem_rdata, 16'h0000);
        check("reset.mem_err", 16'(mem_err), 16'd0);
        check("reset.stall", 16'(mem_stall), 16'd0);
        @(negedge clk); reset = 1'b0;

        run_op("ldr_beef", OP_LDR, 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 2, 1, 16'hBEEF, 16'h0000);
        run_op("stb_odd", OP_STB, 1'b0, 1'b1, 2'b01, 16'h0021, 16'h12AB, 1, 1, 16'h0000, 16'h0000);
        run_op("ldi", OP_LDI, 1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000, 1, 1, 16'h0200, 16'h5A5A);
        run_op("sti", OP_STI, 1'b0, 1'b1, 2'b11, 16'h0104, 16'hC3D4, 1, 2, 16'h0300, 16'h0000);
        run_op("ldb_hi", OP_LDB, 1'b1, 1'b0, 2'b01, 16'h0033, 16'h0000, 1, 1, 16'hA55A, 16'h0000);
        run_op("ld_rw_tie", OP_LDR, 1'b1, 1'b1, 2'b11, 16'h0808, 16'hFFFF, 3, 1, 16'h1357, 16'h0000);

        // Non-memory instruction: no stall, no strobe; stray resp in IDLE is ignored.
        @(negedge clk);
        exmem_valid = 1'b1; opcode = OP_ADD; mem2_read = 1'b0; mem2_write = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
        #1;
        check("alu.stall", 16'(mem_stall), 16'd0);
        @(negedge clk); dmem_resp = 1'b0; #1;
        check("stray_resp.strobes", {dmem_read, dmem_write}, 16'd0);
        check("stray_resp.mem_rdata", mem_rdata, model_rdata);
        exmem_valid = 1'b0;

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(5))
                0: begin op = OP_LDR; rd = 1'b1; wr = 1'($urandom); be = 2'b11; end
                1: begin op = OP_LDB; rd = 1'b1; wr = 1'($urandom); be = 2'b01; end
                2: begin op = OP_LDI; rd = 1'b1; wr = 1'b0; be = 2'b11; end
                3: begin op = OP_STR; rd = 1'b0; wr = 1'b1; be = 2'b11; end
                4: begin op = OP_STB; rd = 1'b0; wr = 1'b1; be = 2'b01; end
                default: begin op = OP_STI; rd = 1'b0; wr = 1'b1; be = 2'b11; end
            endcase
            a = 16'($urandom);
            if (be == 2'b11) a[0] = 1'b0;
            p = 16'($urandom);
            p[0] = 1'b0;
            run_op($sformatf("rand%0d", i), op, rd, wr, be, a, 16'($urandom),
                   int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), p, 16'($urandom));
        end

`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        exmem_valid = 1'b1; opcode = OP_LDR; mem2_read = 1'b1; mem2_write = 1'b0;
        mem_byte_en = 2'b11; addr = 16'h0400;
        strobe_cycles = 0;
        for (int c = 0; c < 40 && mem_stall !== 1'b0; c++) begin
            #1;
            if (mem_stall) begin
                if (dmem_read) strobe_cycles++;
                @(negedge clk);
            end
        end
        #1;
        check("timeout.strobe_cycles", 16'(strobe_cycles), 16'd4);
        check("timeout.resumed", 16'(mem_stall), 16'd0);
        check("timeout.mem_err", 16'(mem_err), 16'd1);
        check("timeout.mem_rdata", mem_rdata, 16'h0000);
        exmem_valid = 1'b0;
        model_rdata = 16'h0000;
`else
        strobe_cycles = 0;
`endif

        // Reset in the middle of an outstanding read.
        @(negedge clk);
        exmem_valid = 1'b1; opcode = OP_LDR; mem2_read = 1'b1; mem2_write = 1'b0;
        mem_byte_en = 2'b11; addr = 16'h0600;
        @(negedge clk); #1;
        check("rst_mid.strobe_up", 16'(dmem_read), 16'd1);
        reset = 1'b1; #1;
        check("rst_mid.strobe_drop", 16'(dmem_read), 16'd0);
        check("rst_mid.mem_err", 16'(mem_err), 16'd0);
        exmem_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        model_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_after.strobes", {dmem_read, dmem_write}, 16'd0);
        check("rst_after.stall", 16'(mem_stall), 16'd0);
        check("rst_after.mem_rdata", mem_rdata, 16'h0000);
        run_op("post_reset_ldr", OP_LDR, 1'b1, 1'b0, 2'b11, 16'h0602, 16'h0000, 1, 1, 16'h7E57, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
